reaction_timer_core: RTL and testbench

Parametrised reaction-time engine for the reaction-time game: a random-delay stimulus, millisecond BCD timing of up to four players, false-start detection, tie flagging and a persistent best-time register. Sits between the button conditioning and the seven-segment display multiplexer in the chip top, replacing the fixed single-player timing logic. Inputs are already synchronised and debounced; this block does its own edge detection.

---
 rtl/reaction_pkg.sv | 22 ++
 rtl/bcd_counter.sv | 52 +++++
 rtl/reaction_timer_core.sv | 156 +++++++++++++++
 tb/tb_reaction_timer_core.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time engine.
package reaction_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ARMED,
    ST_RESULT,
    ST_FAULT
  } state_e;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as a bit mask on [15:0].
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/bcd_counter.sv
// Multi-digit BCD up-counter with synchronous clear; saturates at all 9s.
module bcd_counter
  import reaction_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena_i,
  input  logic                clr_i,
  input  logic                inc_i,
  output logic [4*DIGITS-1:0] count_o,
  output logic                sat_o
);

  logic [4*DIGITS-1:0] count_q, count_d, count_inc;
  bcd_digit_t          dig;
  logic                carry;

  always_comb begin
    count_inc = count_q;
    carry     = 1'b1;
    sat_o     = 1'b1;
    dig       = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dig = count_q[4*i +: 4];
      if (dig != 4'd9) sat_o = 1'b0;
      if (carry) begin
        if (dig == 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = dig + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (clr_i)              count_d = '0;
    else if (inc_i && !sat_o) count_d = count_inc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     count_q <= '0;
    else if (ena_i) count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/reaction_timer_core.sv
// Reaction-time engine: random delay, ms BCD timing, false starts, ties, best time.
// States: IDLE idle | WAIT random delay | ARMED timing react | RESULT show time | FAULT false start
module reaction_timer_core
  import reaction_pkg::*;
#(
  parameter int NUM_PLAYERS  = 2,
  parameter int DIGITS       = 4,
  parameter int TICK_DIV     = 10000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int RAND_BITS    = 11
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic                   start_btn,
  input  logic [NUM_PLAYERS-1:0] react_btn,
  output logic                   stim_led,
  output logic                   busy,
  output logic [NUM_PLAYERS-1:0] winner,
  output logic                   tie,
  output logic [NUM_PLAYERS-1:0] false_start,
  output logic                   timeout,
  output logic [4*DIGITS-1:0]    time_bcd,
  output logic [4*DIGITS-1:0]    best_bcd
);

  localparam int PS_W  = $clog2(TICK_DIV);
  localparam int DLY_W = $clog2(MIN_DELAY_MS + (1 << RAND_BITS));
  localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

  state_e                 state_q, state_d;
  logic [15:0]            lfsr_q;
  logic                   start_q;
  logic [NUM_PLAYERS-1:0] react_q;
  logic [PS_W-1:0]        ps_q, ps_d;
  logic [DLY_W-1:0]       dly_q, dly_d, load_val;
  logic [NUM_PLAYERS-1:0] winner_q, winner_d, fs_q, fs_d;
  logic                   tie_q, tie_d, timeout_q, timeout_d;
  logic [4*DIGITS-1:0]    best_q, best_d, cnt;
  logic                   cnt_clr, cnt_inc, cnt_sat;
  logic                   start_edge, busy_w, tick, react_multi;
  logic [NUM_PLAYERS-1:0] react_edge, react_lowest;

  assign start_edge   = start_btn & ~start_q;
  assign react_edge   = react_btn & ~react_q;
  assign react_lowest = react_edge & (~react_edge + NUM_PLAYERS'(1));
  assign react_multi  = |(react_edge & (react_edge - NUM_PLAYERS'(1)));
  assign busy_w       = (state_q == ST_WAIT) || (state_q == ST_ARMED);
  assign tick         = busy_w && (ps_q == PS_W'(TICK_DIV - 1));
  assign load_val     = DLY_W'(MIN_DELAY_MS) + DLY_W'(lfsr_q[RAND_BITS-1:0]);

  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    ps_d      = (busy_w && !tick) ? ps_q + PS_W'(1) : '0;
    winner_d  = winner_q;
    tie_d     = tie_q;
    fs_d      = fs_q;
    timeout_d = timeout_q;
    best_d    = best_q;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state_q)
      ST_IDLE, ST_RESULT, ST_FAULT: begin
        if (start_edge) begin
          state_d   = ST_WAIT;
          dly_d     = load_val;
          ps_d      = '0;
          winner_d  = '0;
          tie_d     = 1'b0;
          fs_d      = '0;
          timeout_d = 1'b0;
          cnt_clr   = 1'b1;
        end
      end
      ST_WAIT: begin
        // A press beats delay expiry in the same cycle.
        if (|react_edge) begin
          state_d = ST_FAULT;
          fs_d    = react_edge;
          ps_d    = '0;
        end else if (dly_q == '0 || (tick && dly_q == DLY_W'(1))) begin
          state_d = ST_ARMED;
          ps_d    = '0;
          cnt_clr = 1'b1;
        end else if (tick) begin
          dly_d = dly_q - DLY_W'(1);
        end
      end
      ST_ARMED: begin
        if (|react_edge) begin
          state_d  = ST_RESULT;
          winner_d = react_lowest;
          tie_d    = react_multi;
          ps_d     = '0;
          if (cnt < best_q) best_d = cnt;
        end else if (cnt_sat) begin
          state_d   = ST_RESULT;
          timeout_d = 1'b1;
          ps_d      = '0;
        end else if (tick) begin
          cnt_inc = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      lfsr_q    <= LFSR_SEED;
      start_q   <= 1'b0;
      react_q   <= '0;
      ps_q      <= '0;
      dly_q     <= '0;
      winner_q  <= '0;
      tie_q     <= 1'b0;
      fs_q      <= '0;
      timeout_q <= 1'b0;
      best_q    <= ALL_NINES;
    end else if (ena) begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_next(lfsr_q);
      start_q   <= start_btn;
      react_q   <= react_btn;
      ps_q      <= ps_d;
      dly_q     <= dly_d;
      winner_q  <= winner_d;
      tie_q     <= tie_d;
      fs_q      <= fs_d;
      timeout_q <= timeout_d;
      best_q    <= best_d;
    end
  end

  bcd_counter #(.DIGITS(DIGITS)) u_time (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena_i   (ena),
    .clr_i   (cnt_clr),
    .inc_i   (cnt_inc),
    .count_o (cnt),
    .sat_o   (cnt_sat)
  );

  assign stim_led    = (state_q == ST_ARMED);
  assign busy        = busy_w;
  assign winner      = winner_q;
  assign tie         = tie_q;
  assign false_start = fs_q;
  assign timeout     = timeout_q;
  assign time_bcd    = cnt;
  assign best_bcd    = best_q;

endmodule

// File: tb/tb_reaction_timer_core.sv
// Scoreboard bench for reaction_timer_core with a cycle-level reference of the game rules.
module tb_reaction_timer_core;

  localparam int NP = 2, DG = 2, TD = 4, MIN_D = 2, RB = 2;

  logic          clk = 1'b0, rst_n = 1'b0, ena = 1'b1, start_btn = 1'b0;
  logic [NP-1:0] react_btn = '0;
  logic          stim_led, busy, tie, timeout;
  logic [NP-1:0] winner, false_start;
  logic [4*DG-1:0] time_bcd, best_bcd;

  reaction_timer_core #(
    .NUM_PLAYERS(NP), .DIGITS(DG), .TICK_DIV(TD), .MIN_DELAY_MS(MIN_D), .RAND_BITS(RB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start_btn(start_btn), .react_btn(react_btn),
    .stim_led(stim_led), .busy(busy), .winner(winner), .tie(tie),
    .false_start(false_start), .timeout(timeout), .time_bcd(time_bcd), .best_bcd(best_bcd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NP-1:0] winner;
    logic          tie;
    logic [NP-1:0] fs;
    logic          timeout;
    logic [7:0]    time_v;
    logic [7:0]    best;
  } exp_t;

  exp_t       res_q[$];
  int         stim_q[$];
  int         checks = 0, errors = 0;
  logic [7:0] best_m = 8'h99;
  logic [15:0] m_lfsr;

  // Reference stimulus generator: 16-bit Fibonacci, taps 16,14,13,11.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else if (ena) m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int t);
    return 8'(((t / 10) % 10) * 16 + (t % 10));
  endfunction

  function automatic logic [NP-1:0] lowest(input logic [NP-1:0] m);
    for (int i = 0; i < NP; i++) if (m[i]) return NP'(1) << i;
    return '0;
  endfunction

  // Monitor: stim_led rise checks delay, busy fall checks the finished game.
  logic busy_p = 1'b0, stim_p = 1'b0;
  int   wcnt = 0;
  exp_t e;
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_p = 1'b0; stim_p = 1'b0; wcnt = 0;
    end else begin
      if (busy && !busy_p) wcnt = 0;
      else wcnt++;
      if (stim_led && !stim_p) begin
        if (stim_q.size() == 0) check("stim_unexpected", stim_led, 0);
        else check("stim_delay", wcnt, stim_q.pop_front());
      end
      if (!busy && busy_p) begin
        if (res_q.size() == 0) check("result_unexpected", busy, 1);
        else begin
          e = res_q.pop_front();
          check("winner", winner, e.winner);
          check("tie", tie, e.tie);
          check("false_start", false_start, e.fs);
          check("timeout", timeout, e.timeout);
          check("time_bcd", time_bcd, e.time_v);
          check("best_bcd", best_bcd, e.best);
          check("stim_off", stim_led, 0);
        end
      end
      busy_p = busy; stim_p = stim_led;
    end
  end

  task automatic start_game(input int hold, input bit armed, output int d);
    @(negedge clk);
    d = MIN_D + int'(m_lfsr[RB-1:0]);
    start_btn = 1'b1;
    if (armed) stim_q.push_back(d * TD + hold);
    @(negedge clk);
    start_btn = 1'b0;
    if (hold > 0) begin
      ena = 1'b0;
      repeat (hold) @(negedge clk);
      ena = 1'b1;
    end
  endtask

  task automatic wait_stim(output bit ok);
    int n = 0;
    while (!stim_led && n < 2000) begin @(negedge clk); n++; end
    ok = stim_led;
    if (!ok) check("stim_wait_timeout", stim_led, 1);
  endtask

  // Press sampled k edges after ARMED entry; ticks strictly before that edge count.
  task automatic press_after(input int k, input logic [NP-1:0] mask);
    bit   ok;
    int   t;
    exp_t x;
    wait_stim(ok);
    if (!ok) return;
    repeat (k - 1) @(negedge clk);
    t = (k - 1) / TD;
    if (t > 99) t = 99;
    x.winner = lowest(mask); x.tie = ($countones(mask) > 1); x.fs = '0;
    x.timeout = 1'b0; x.time_v = to_bcd(t);
    if (x.time_v < best_m) best_m = x.time_v;
    x.best = best_m;
    res_q.push_back(x);
    react_btn = mask;
    @(negedge clk);
    react_btn = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic fault_game(input int j_sel, input logic [NP-1:0] mask);
    int   d, j;
    exp_t x;
    start_game(0, 1'b0, d);
    j = (j_sel == 0 || j_sel > d * TD) ? d * TD : j_sel;
    repeat (j - 1) @(negedge clk);
    x.winner = '0; x.tie = 1'b0; x.fs = mask; x.timeout = 1'b0;
    x.time_v = 8'h00; x.best = best_m;
    res_q.push_back(x);
    react_btn = mask;
    @(negedge clk);
    react_btn = '0;
    repeat (3 * TD) @(negedge clk);
  endtask

  task automatic timeout_game();
    int   d, n;
    exp_t x;
    start_game(0, 1'b1, d);
    x.winner = '0; x.tie = 1'b0; x.fs = '0; x.timeout = 1'b1;
    x.time_v = 8'h99; x.best = best_m;
    res_q.push_back(x);
    n = 0;
    while (busy && n < 100 * TD + d * TD + 50) begin @(negedge clk); n++; end
    if (busy) check("timeout_wait", busy, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int  d, r;
    bit  ok;
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int  d, r;
    bit  ok;
    repeat (3) @(negedge clk);
    check("rst_stim", stim_led, 0);
    check("rst_busy", busy, 0);
    check("rst_winner", winner, 0);
    check("rst_tie", tie, 0);
    check("rst_fs", false_start, 0);
    check("rst_timeout", timeout, 0);
    check("rst_time", time_bcd, 0);
    check("rst_best", best_bcd, 8'h99);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check("idle_stim", stim_led, 0);
    check("idle_busy", busy, 0);

    start_game(0, 1'b1, d);
    press_after(5 * TD + 1, 2'b10);
    start_game(0, 1'b1, d);
    press_after(3 * TD + 1, 2'b11);
    fault_game(3, 2'b01);
    fault_game(0, 2'b10);
    timeout_game();
    start_game(20, 1'b1, d);
    press_after(2 * TD, 2'b01);
    start_game(0, 1'b1, d);
    press_after(1, 2'b10);

    for (int g = 0; g < 12; g++) begin
      r = $urandom_range(0, 5);
      if (r == 5) timeout_game();
      else if (r == 4) fault_game($urandom_range(1, 12), NP'($urandom_range(1, 3)));
      else begin
        start_game((r == 3) ? $urandom_range(1, 6) : 0, 1'b1, d);
        press_after($urandom_range(1, 60), NP'($urandom_range(1, 3)));
      end
    end

    start_game(0, 1'b1, d);
    wait_stim(ok);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_stim", stim_led, 0);
    check("midrst_busy", busy, 0);
    check("midrst_best", best_bcd, 8'h99);
    check("midrst_time", time_bcd, 0);
    best_m = 8'h99;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start_game(0, 1'b1, d);
    press_after(7 * TD + 1, 2'b01);

    repeat (5) @(negedge clk);
    check("queues_drained", res_q.size() + stim_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
